// File: rtl/pifo_pkg.sv
// Shared definitions for the register-based PIFO: overflow policy encodings
// and the stored-entry width helper.
package pifo_pkg;

  localparam int unsigned DROP_EVICT_MAX = 0;
  localparam int unsigned DROP_TAIL      = 1;

  // Each slot holds {rank, meta} packed together, rank in the upper bits.
  function automatic int unsigned entry_width(input int unsigned rank_w,
                                              input int unsigned meta_w);
    return rank_w + meta_w;
  endfunction

endpackage

// File: rtl/pifo_minmax_tree.sv
// Combinational min/max reduction over the PIFO slots. Min ties go to the
// lowest slot (oldest), max ties go to the highest slot (youngest).
module pifo_minmax_tree #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned RANK_WIDTH = 16
) (
  input  logic [DEPTH-1:0]            valid,
  input  logic [DEPTH*RANK_WIDTH-1:0] rank,
  output logic [$clog2(DEPTH)-1:0]    min_idx,
  output logic [$clog2(DEPTH)-1:0]    max_idx
);

  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned LEAVES = 1 << IDX_W;
  localparam int unsigned NODES  = 2 * LEAVES - 1;

  typedef struct packed {
    logic                  v;
    logic [RANK_WIDTH-1:0] r;
    logic [IDX_W-1:0]      i;
  } node_t;

  // Right child (younger) wins only if strictly smaller.
  function automatic node_t pick_min(input node_t a, input node_t b);
    return (b.v && (!a.v || (b.r < a.r))) ? b : a;
  endfunction

  // Right child (younger) wins on equality.
  function automatic node_t pick_max(input node_t a, input node_t b);
    return (b.v && (!a.v || (b.r >= a.r))) ? b : a;
  endfunction

  // Heap-ordered tree; leaves beyond DEPTH are padded as invalid.
  function automatic logic [2*IDX_W-1:0] reduce(
    input logic [DEPTH-1:0]            v,
    input logic [DEPTH*RANK_WIDTH-1:0] r
  );
    logic [LEAVES-1:0]            v_pad;
    logic [LEAVES*RANK_WIDTH-1:0] r_pad;
    node_t                        mn [NODES];
    node_t                        mx [NODES];
    v_pad = LEAVES'(v);
    r_pad = (LEAVES*RANK_WIDTH)'(r);
    for (int l = 0; l < int'(LEAVES); l++) begin
      mn[int'(LEAVES) - 1 + l] = node_t'{v_pad[l], r_pad[l*RANK_WIDTH +: RANK_WIDTH], IDX_W'(l)};
      mx[int'(LEAVES) - 1 + l] = mn[int'(LEAVES) - 1 + l];
    end
    for (int n = int'(LEAVES) - 2; n >= 0; n--) begin
      mn[n] = pick_min(mn[2*n+1], mn[2*n+2]);
      mx[n] = pick_max(mx[2*n+1], mx[2*n+2]);
    end
    return {mn[0].i, mx[0].i};
  endfunction

  assign {min_idx, max_idx} = reduce(valid, rank);

endmodule

// File: rtl/pifo_reg_v2.sv
// Register-array PIFO: arrival-ordered slots, min-rank dequeue, and an
// overflow drop port with either evict-max or tail-drop policy.
module pifo_reg_v2 import pifo_pkg::*; #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned RANK_WIDTH  = 16,
  parameter int unsigned META_WIDTH  = 12,
  parameter int unsigned DROP_POLICY = DROP_EVICT_MAX
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ins_valid,
  output logic                       ins_ready,
  input  logic [RANK_WIDTH-1:0]      ins_rank,
  input  logic [META_WIDTH-1:0]      ins_meta,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output logic [RANK_WIDTH-1:0]      deq_rank,
  output logic [META_WIDTH-1:0]      deq_meta,
  output logic                       drop_valid,
  output logic [RANK_WIDTH-1:0]      drop_rank,
  output logic [META_WIDTH-1:0]      drop_meta,
  output logic [$clog2(DEPTH+1)-1:0] num_entries,
  output logic                       empty,
  output logic                       full,
  output logic [31:0]                drop_count
);

  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W   = $clog2(DEPTH);
  localparam int unsigned ENTRY_W = entry_width(RANK_WIDTH, META_WIDTH);

  logic [ENTRY_W-1:0]          slot_q [DEPTH];
  logic [ENTRY_W-1:0]          slot_n [DEPTH];
  logic [DEPTH-1:0]            valid_q, valid_n;
  logic [CNT_W-1:0]            count_q, count_n;
  logic                        empty_q, full_q, ins_ready_q;
  logic                        drop_valid_q;
  logic [ENTRY_W-1:0]          drop_entry_q;
  logic [31:0]                 drop_count_q;

  logic [DEPTH*RANK_WIDTH-1:0] rank_flat;
  logic [IDX_W-1:0]            min_idx, max_idx;
  logic [ENTRY_W-1:0]          ins_entry, head_entry, victim_entry, drop_entry;
  logic [RANK_WIDTH-1:0]       victim_rank;
  logic                        do_deq, do_ins;
  logic                        remove_en, append_en, drop_en;
  logic [IDX_W-1:0]            remove_idx;
  logic [CNT_W-1:0]            append_pos;

  always_comb begin
    rank_flat = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      rank_flat[i*RANK_WIDTH +: RANK_WIDTH] = slot_q[i][ENTRY_W-1 -: RANK_WIDTH];
    end
  end

  pifo_minmax_tree #(
    .DEPTH      (DEPTH),
    .RANK_WIDTH (RANK_WIDTH)
  ) u_tree (
    .valid   (valid_q),
    .rank    (rank_flat),
    .min_idx (min_idx),
    .max_idx (max_idx)
  );

  assign ins_entry    = {ins_rank, ins_meta};
  assign head_entry   = slot_q[min_idx];
  assign victim_entry = slot_q[max_idx];
  assign victim_rank  = victim_entry[ENTRY_W-1 -: RANK_WIDTH];

  // Decide what leaves the array (head or victim), what enters, what drops.
  always_comb begin
    do_deq     = deq_ready && !empty_q;
    do_ins     = ins_valid && ins_ready_q;
    remove_en  = 1'b0;
    remove_idx = '0;
    append_en  = 1'b0;
    drop_en    = 1'b0;
    drop_entry = ins_entry;
    if (do_deq) begin
      remove_en  = 1'b1;
      remove_idx = min_idx;
    end
    if (do_ins) begin
      if (!full_q || do_deq) begin
        append_en = 1'b1;
      end else if ((DROP_POLICY == DROP_EVICT_MAX) && (ins_rank < victim_rank)) begin
        remove_en  = 1'b1;
        remove_idx = max_idx;
        append_en  = 1'b1;
        drop_en    = 1'b1;
        drop_entry = victim_entry;
      end else begin
        drop_en = 1'b1;
      end
    end
  end

  // Remove by shifting younger slots down, then append at the new tail.
  always_comb begin
    slot_n     = slot_q;
    valid_n    = valid_q;
    append_pos = count_q - CNT_W'(remove_en);
    if (remove_en) begin
      for (int i = 0; i < int'(DEPTH) - 1; i++) begin
        if (i >= int'(remove_idx)) begin
          slot_n[i]  = slot_q[i+1];
          valid_n[i] = valid_q[i+1];
        end
      end
      valid_n[DEPTH-1] = 1'b0;
    end
    if (append_en) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (CNT_W'(i) == append_pos) begin
          slot_n[i]  = ins_entry;
          valid_n[i] = 1'b1;
        end
      end
    end
    count_n = append_pos + CNT_W'(append_en);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= '0;
      count_q      <= '0;
      empty_q      <= 1'b1;
      full_q       <= 1'b0;
      ins_ready_q  <= 1'b0;
      drop_valid_q <= 1'b0;
      drop_count_q <= '0;
    end else begin
      valid_q      <= valid_n;
      count_q      <= count_n;
      empty_q      <= (count_n == '0);
      full_q       <= (count_n == CNT_W'(DEPTH));
      ins_ready_q  <= 1'b1;
      drop_valid_q <= drop_en;
      if (drop_en && (drop_count_q != '1)) begin
        drop_count_q <= drop_count_q + 32'd1;
      end
    end
  end

  // Payload storage needs no reset; validity is tracked by valid_q/count_q.
  always_ff @(posedge clk) begin
    slot_q <= slot_n;
    if (drop_en) begin
      drop_entry_q <= drop_entry;
    end
  end

  assign ins_ready   = ins_ready_q;
  assign deq_valid   = !empty_q;
  assign deq_rank    = head_entry[ENTRY_W-1 -: RANK_WIDTH];
  assign deq_meta    = head_entry[META_WIDTH-1:0];
  assign drop_valid  = drop_valid_q;
  assign drop_rank   = drop_entry_q[ENTRY_W-1 -: RANK_WIDTH];
  assign drop_meta   = drop_entry_q[META_WIDTH-1:0];
  assign num_entries = count_q;
  assign empty       = empty_q;
  assign full        = full_q;
  assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_pifo_reg_v2.sv
// Bench for pifo_reg_v2: two DEPTH=4 instances (evict-max and tail-drop) share
// stimulus and are compared against an arrival-ordered array model.
module tb_pifo_reg_v2;

  localparam int DEPTH = 4;
  localparam int RW    = 16;
  localparam int MW    = 12;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ins_valid = 1'b0;
  logic [RW-1:0] ins_rank = '0;
  logic [MW-1:0] ins_meta = '0;
  logic          deq_ready = 1'b0;

  logic          ins_ready   [2];
  logic          deq_valid   [2];
  logic [RW-1:0] deq_rank    [2];
  logic [MW-1:0] deq_meta    [2];
  logic          drop_valid  [2];
  logic [RW-1:0] drop_rank   [2];
  logic [MW-1:0] drop_meta   [2];
  logic [CW-1:0] num_entries [2];
  logic          empty       [2];
  logic          full        [2];
  logic [31:0]   drop_count  [2];

  always #5 clk = ~clk;

  pifo_reg_v2 #(.DEPTH(DEPTH), .RANK_WIDTH(RW), .META_WIDTH(MW), .DROP_POLICY(0)) dut0 (
    .clk(clk), .rst(rst), .ins_valid(ins_valid), .ins_ready(ins_ready[0]),
    .ins_rank(ins_rank), .ins_meta(ins_meta), .deq_valid(deq_valid[0]),
    .deq_ready(deq_ready), .deq_rank(deq_rank[0]), .deq_meta(deq_meta[0]),
    .drop_valid(drop_valid[0]), .drop_rank(drop_rank[0]), .drop_meta(drop_meta[0]),
    .num_entries(num_entries[0]), .empty(empty[0]), .full(full[0]),
    .drop_count(drop_count[0]));

  pifo_reg_v2 #(.DEPTH(DEPTH), .RANK_WIDTH(RW), .META_WIDTH(MW), .DROP_POLICY(1)) dut1 (
    .clk(clk), .rst(rst), .ins_valid(ins_valid), .ins_ready(ins_ready[1]),
    .ins_rank(ins_rank), .ins_meta(ins_meta), .deq_valid(deq_valid[1]),
    .deq_ready(deq_ready), .deq_rank(deq_rank[1]), .deq_meta(deq_meta[1]),
    .drop_valid(drop_valid[1]), .drop_rank(drop_rank[1]), .drop_meta(drop_meta[1]),
    .num_entries(num_entries[1]), .empty(empty[1]), .full(full[1]),
    .drop_count(drop_count[1]));

  int errors = 0;
  int checks = 0;

  // Model: entries in arrival order, index 0 oldest; model 0 evicts, model 1 tail-drops.
  int     m_rank [2][DEPTH];
  int     m_meta [2][DEPTH];
  int     m_n    [2];
  bit     m_dv   [2];
  int     m_dr   [2];
  int     m_dm   [2];
  longint m_dc   [2];
  bit     m_rdy;

  function automatic int head_idx(input int p);
    int best = 0;
    for (int i = 1; i < m_n[p]; i++) if (m_rank[p][i] < m_rank[p][best]) best = i;
    return best;
  endfunction

  function automatic int victim_idx(input int p);
    int best = 0;
    for (int i = 1; i < m_n[p]; i++) if (m_rank[p][i] >= m_rank[p][best]) best = i;
    return best;
  endfunction

  function automatic void remove_at(input int p, input int k);
    for (int i = k; i < m_n[p] - 1; i++) begin
      m_rank[p][i] = m_rank[p][i+1];
      m_meta[p][i] = m_meta[p][i+1];
    end
    m_n[p]--;
  endfunction

  function automatic void append(input int p, input int r, input int m);
    m_rank[p][m_n[p]] = r;
    m_meta[p][m_n[p]] = m;
    m_n[p]++;
  endfunction

  function automatic void model_step(input bit iv, input int ir, input int im, input bit dr);
    for (int p = 0; p < 2; p++) begin
      bit was_full;
      bit did_deq;
      int k;
      was_full = (m_n[p] == DEPTH);
      did_deq  = dr && (m_n[p] > 0);
      m_dv[p]  = 1'b0;
      if (did_deq) remove_at(p, head_idx(p));
      if (iv && m_rdy) begin
        if (!was_full || did_deq) begin
          append(p, ir, im);
        end else if (p == 0 && ir < m_rank[p][victim_idx(p)]) begin
          k = victim_idx(p);
          m_dv[p] = 1'b1; m_dr[p] = m_rank[p][k]; m_dm[p] = m_meta[p][k];
          remove_at(p, k);
          append(p, ir, im);
        end else begin
          m_dv[p] = 1'b1; m_dr[p] = ir; m_dm[p] = im;
        end
      end
      if (m_dv[p] && m_dc[p] < 64'hFFFF_FFFF) m_dc[p]++;
    end
    m_rdy = 1'b1;
  endfunction

  task automatic cycle(input bit iv, input int ir, input int im, input bit dr);
    ins_valid = iv; ins_rank = 16'(ir); ins_meta = 12'(im); deq_ready = dr;
    @(posedge clk);
    model_step(iv, ir, im, dr);
    #1;
    ins_valid = 1'b0; deq_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    for (int p = 0; p < 2; p++) begin m_n[p] = 0; m_dv[p] = 0; m_dc[p] = 0; end
    m_rdy = 1'b0;
    #1;
    rst = 1'b0;
  endtask

  task automatic fresh();
    do_reset();
    cycle(0, 0, 0, 0);
  endtask

  task automatic fill_10_40();
    for (int k = 1; k <= 4; k++) cycle(1, 10 * k, 100 + k, 0);
  endtask

  task automatic test_reset();
    do_reset();
    checks += 7;
    if (num_entries[0] !== 3'd0) begin errors++; $display("FAIL reset_num: got %0d expected 0", num_entries[0]); end
    if (empty[0] !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty[0]); end
    if (full[0] !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full[0]); end
    if (deq_valid[0] !== 1'b0) begin errors++; $display("FAIL reset_deq_valid: got %b expected 0", deq_valid[0]); end
    if (ins_ready[0] !== 1'b0) begin errors++; $display("FAIL reset_ins_ready: got %b expected 0", ins_ready[0]); end
    if (drop_valid[0] !== 1'b0) begin errors++; $display("FAIL reset_drop_valid: got %b expected 0", drop_valid[0]); end
    if (drop_count[0] !== 32'd0) begin errors++; $display("FAIL reset_drop_count: got %0d expected 0", drop_count[0]); end
    cycle(0, 0, 0, 0);
    checks += 2;
    if (ins_ready[0] !== 1'b1) begin errors++; $display("FAIL ready_after_reset dut0: got %b expected 1", ins_ready[0]); end
    if (ins_ready[1] !== 1'b1) begin errors++; $display("FAIL ready_after_reset dut1: got %b expected 1", ins_ready[1]); end
  endtask

  task automatic test_order();
    int exp_r [3] = '{3, 5, 7};
    fresh();
    cycle(1, 5, 0, 0);
    checks += 2;
    if (deq_valid[0] !== 1'b1) begin errors++; $display("FAIL order_visible_valid: got %b expected 1", deq_valid[0]); end
    if (deq_rank[0] !== 16'd5) begin errors++; $display("FAIL order_visible_rank: got %0d expected 5", deq_rank[0]); end
    cycle(1, 3, 0, 0);
    cycle(1, 7, 0, 0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (deq_rank[0] !== 16'(exp_r[k])) begin errors++; $display("FAIL order_deq%0d: got %0d expected %0d", k, deq_rank[0], exp_r[k]); end
      cycle(0, 0, 0, 1);
    end
    checks += 2;
    if (empty[0] !== 1'b1) begin errors++; $display("FAIL order_empty: got %b expected 1", empty[0]); end
    if (deq_valid[0] !== 1'b0) begin errors++; $display("FAIL order_deq_valid: got %b expected 0", deq_valid[0]); end
  endtask

  task automatic test_ties();
    fresh();
    for (int k = 1; k <= 3; k++) cycle(1, 4, k, 0);
    for (int k = 1; k <= 3; k++) begin
      checks += 2;
      if (deq_meta[0] !== 12'(k)) begin errors++; $display("FAIL tie_meta dut0 #%0d: got %0d expected %0d", k, deq_meta[0], k); end
      if (deq_meta[1] !== 12'(k)) begin errors++; $display("FAIL tie_meta dut1 #%0d: got %0d expected %0d", k, deq_meta[1], k); end
      cycle(0, 0, 0, 1);
    end
  endtask

  task automatic test_evict();
    int exp0 [4] = '{10, 20, 25, 30};
    int exp1 [4] = '{10, 20, 30, 40};
    fresh();
    fill_10_40();
    checks += 2;
    if (full[0] !== 1'b1) begin errors++; $display("FAIL evict_full: got %b expected 1", full[0]); end
    if (num_entries[0] !== 3'd4) begin errors++; $display("FAIL evict_num_before: got %0d expected 4", num_entries[0]); end
    cycle(1, 25, 77, 0);
    checks += 8;
    if (drop_valid[0] !== 1'b1) begin errors++; $display("FAIL evict_drop_valid: got %b expected 1", drop_valid[0]); end
    if (drop_rank[0] !== 16'd40) begin errors++; $display("FAIL evict_drop_rank: got %0d expected 40", drop_rank[0]); end
    if (drop_meta[0] !== 12'd104) begin errors++; $display("FAIL evict_drop_meta: got %0d expected 104", drop_meta[0]); end
    if (drop_count[0] !== 32'd1) begin errors++; $display("FAIL evict_drop_count: got %0d expected 1", drop_count[0]); end
    if (num_entries[0] !== 3'd4) begin errors++; $display("FAIL evict_num: got %0d expected 4", num_entries[0]); end
    if (drop_valid[1] !== 1'b1) begin errors++; $display("FAIL tail_drop_valid: got %b expected 1", drop_valid[1]); end
    if (drop_rank[1] !== 16'd25) begin errors++; $display("FAIL tail_drop_rank: got %0d expected 25", drop_rank[1]); end
    if (drop_count[1] !== 32'd1) begin errors++; $display("FAIL tail_drop_count: got %0d expected 1", drop_count[1]); end
    cycle(0, 0, 0, 0);
    checks += 2;
    if (drop_valid[0] !== 1'b0) begin errors++; $display("FAIL evict_pulse_width: got %b expected 0", drop_valid[0]); end
    if (drop_count[0] !== 32'd1) begin errors++; $display("FAIL evict_count_hold: got %0d expected 1", drop_count[0]); end
    for (int k = 0; k < 4; k++) begin
      checks += 2;
      if (deq_rank[0] !== 16'(exp0[k])) begin errors++; $display("FAIL evict_deq%0d dut0: got %0d expected %0d", k, deq_rank[0], exp0[k]); end
      if (deq_rank[1] !== 16'(exp1[k])) begin errors++; $display("FAIL evict_deq%0d dut1: got %0d expected %0d", k, deq_rank[1], exp1[k]); end
      cycle(0, 0, 0, 1);
    end
  endtask

  task automatic test_no_benefit();
    fresh();
    fill_10_40();
    cycle(1, 50, 5, 0);
    checks += 2;
    if (drop_rank[0] !== 16'd50) begin errors++; $display("FAIL nobenefit_rank: got %0d expected 50", drop_rank[0]); end
    if (drop_meta[0] !== 12'd5) begin errors++; $display("FAIL nobenefit_meta: got %0d expected 5", drop_meta[0]); end
    cycle(1, 40, 7, 0);
    checks += 4;
    if (drop_valid[0] !== 1'b1) begin errors++; $display("FAIL equal_rank_valid: got %b expected 1", drop_valid[0]); end
    if (drop_rank[0] !== 16'd40) begin errors++; $display("FAIL equal_rank_rank: got %0d expected 40", drop_rank[0]); end
    if (drop_meta[0] !== 12'd7) begin errors++; $display("FAIL equal_rank_meta: got %0d expected 7", drop_meta[0]); end
    if (drop_count[0] !== 32'd2) begin errors++; $display("FAIL equal_rank_count: got %0d expected 2", drop_count[0]); end
    for (int k = 1; k <= 4; k++) begin
      checks += 2;
      if (deq_rank[0] !== 16'(10 * k)) begin errors++; $display("FAIL nobenefit_deq%0d rank: got %0d expected %0d", k, deq_rank[0], 10 * k); end
      if (deq_meta[0] !== 12'(100 + k)) begin errors++; $display("FAIL nobenefit_deq%0d meta: got %0d expected %0d", k, deq_meta[0], 100 + k); end
      cycle(0, 0, 0, 1);
    end
  endtask

  task automatic test_simul();
    fresh();
    fill_10_40();
    checks++;
    if (deq_rank[0] !== 16'd10) begin errors++; $display("FAIL simul_head_before: got %0d expected 10", deq_rank[0]); end
    cycle(1, 1, 55, 1);
    checks += 5;
    if (drop_valid[0] !== 1'b0) begin errors++; $display("FAIL simul_no_drop dut0: got %b expected 0", drop_valid[0]); end
    if (drop_valid[1] !== 1'b0) begin errors++; $display("FAIL simul_no_drop dut1: got %b expected 0", drop_valid[1]); end
    if (num_entries[0] !== 3'd4) begin errors++; $display("FAIL simul_num: got %0d expected 4", num_entries[0]); end
    if (deq_rank[0] !== 16'd1) begin errors++; $display("FAIL simul_next_head: got %0d expected 1", deq_rank[0]); end
    if (deq_meta[0] !== 12'd55) begin errors++; $display("FAIL simul_next_meta: got %0d expected 55", deq_meta[0]); end
  endtask

  task automatic test_deq_empty();
    fresh();
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    checks += 3;
    if (num_entries[0] !== 3'd0) begin errors++; $display("FAIL deq_empty_num: got %0d expected 0", num_entries[0]); end
    if (empty[0] !== 1'b1) begin errors++; $display("FAIL deq_empty_empty: got %b expected 1", empty[0]); end
    if (deq_valid[0] !== 1'b0) begin errors++; $display("FAIL deq_empty_valid: got %b expected 0", deq_valid[0]); end
    cycle(1, 9, 3, 0);
    checks += 2;
    if (num_entries[0] !== 3'd1) begin errors++; $display("FAIL deq_empty_then_ins_num: got %0d expected 1", num_entries[0]); end
    if (deq_rank[0] !== 16'd9) begin errors++; $display("FAIL deq_empty_then_ins_rank: got %0d expected 9", deq_rank[0]); end
  endtask

  task automatic test_midreset();
    fresh();
    for (int k = 0; k < 3; k++) cycle(1, 6 + k, k, 0);
    do_reset();
    checks += 4;
    if (num_entries[0] !== 3'd0) begin errors++; $display("FAIL midrst_num: got %0d expected 0", num_entries[0]); end
    if (empty[0] !== 1'b1) begin errors++; $display("FAIL midrst_empty: got %b expected 1", empty[0]); end
    if (deq_valid[0] !== 1'b0) begin errors++; $display("FAIL midrst_deq_valid: got %b expected 0", deq_valid[0]); end
    if (drop_count[0] !== 32'd0) begin errors++; $display("FAIL midrst_drop_count: got %0d expected 0", drop_count[0]); end
    cycle(0, 0, 0, 0);
    checks++;
    if (ins_ready[0] !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b expected 1", ins_ready[0]); end
    // Full with a prior drop, then a drop-causing insert in the reset cycle.
    fill_10_40();
    cycle(1, 60, 0, 0);
    ins_valid = 1'b1; ins_rank = 16'd1; ins_meta = 12'd9;
    do_reset();
    ins_valid = 1'b0;
    checks += 3;
    if (drop_valid[0] !== 1'b0) begin errors++; $display("FAIL midrst_pending_drop: got %b expected 0", drop_valid[0]); end
    if (drop_count[0] !== 32'd0) begin errors++; $display("FAIL midrst_count_clear: got %0d expected 0", drop_count[0]); end
    if (num_entries[0] !== 3'd0) begin errors++; $display("FAIL midrst_full_num: got %0d expected 0", num_entries[0]); end
  endtask

  task automatic test_random();
    fresh();
    for (int c = 0; c < 800; c++) begin
      for (int p = 0; p < 2; p++) begin
        checks += 5;
        if (num_entries[p] !== 3'(m_n[p])) begin errors++; $display("FAIL rand_num dut%0d c%0d: got %0d expected %0d", p, c, num_entries[p], m_n[p]); end
        if (deq_valid[p] !== (m_n[p] != 0)) begin errors++; $display("FAIL rand_deq_valid dut%0d c%0d: got %b expected %b", p, c, deq_valid[p], m_n[p] != 0); end
        if (full[p] !== (m_n[p] == DEPTH)) begin errors++; $display("FAIL rand_full dut%0d c%0d: got %b expected %b", p, c, full[p], m_n[p] == DEPTH); end
        if (drop_valid[p] !== m_dv[p]) begin errors++; $display("FAIL rand_drop_valid dut%0d c%0d: got %b expected %b", p, c, drop_valid[p], m_dv[p]); end
        if (drop_count[p] !== 32'(m_dc[p])) begin errors++; $display("FAIL rand_drop_count dut%0d c%0d: got %0d expected %0d", p, c, drop_count[p], m_dc[p]); end
        if (m_n[p] != 0) begin
          checks += 2;
          if (deq_rank[p] !== 16'(m_rank[p][head_idx(p)])) begin errors++; $display("FAIL rand_deq_rank dut%0d c%0d: got %0d expected %0d", p, c, deq_rank[p], m_rank[p][head_idx(p)]); end
          if (deq_meta[p] !== 12'(m_meta[p][head_idx(p)])) begin errors++; $display("FAIL rand_deq_meta dut%0d c%0d: got %0d expected %0d", p, c, deq_meta[p], m_meta[p][head_idx(p)]); end
        end
        if (m_dv[p]) begin
          checks += 2;
          if (drop_rank[p] !== 16'(m_dr[p])) begin errors++; $display("FAIL rand_drop_rank dut%0d c%0d: got %0d expected %0d", p, c, drop_rank[p], m_dr[p]); end
          if (drop_meta[p] !== 12'(m_dm[p])) begin errors++; $display("FAIL rand_drop_meta dut%0d c%0d: got %0d expected %0d", p, c, drop_meta[p], m_dm[p]); end
        end
      end
      cycle(($urandom % 4) != 0, int'($urandom_range(0, 15)), int'($urandom % 4096),
            (c < 400) ? (($urandom % 3) == 0) : (($urandom % 5) < 3));
    end
  endtask

  initial begin
    test_reset();
    test_order();
    test_ties();
    test_evict();
    test_no_benefit();
    test_simul();
    test_deq_empty();
    test_midreset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pifo_reg_v2.md
PIFO_REG_V2 -- requirements
Module: pifo_reg_v2

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of entries (any integer 2..64, not restricted to powers of two).
REQ-002 SHALL have parameter RANK_WIDTH, default 16, rank bits (unsigned; lower rank = higher priority).
REQ-003 SHALL have parameter META_WIDTH, default 12, metadata bits.
REQ-004 SHALL have parameter DROP_POLICY, default 0, overflow mode: 0 = evict max if beneficial, 1 = tail drop.
REQ-005 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port ins_valid  input  1  insert request.
REQ-008 SHALL have port ins_ready  output  1  insert accepted when ins_valid & ins_ready.
REQ-009 SHALL have port ins_rank  input  RANK_WIDTH  rank of inserted entry.
REQ-010 SHALL have port ins_meta  input  META_WIDTH  metadata of inserted entry.
REQ-011 SHALL have port deq_valid  output  1  head entry available.
REQ-012 SHALL have port deq_ready  input  1  dequeue when deq_valid & deq_ready.
REQ-013 SHALL have port deq_rank  output  RANK_WIDTH  minimum-rank entry rank.
REQ-014 SHALL have port deq_meta  output  META_WIDTH  minimum-rank entry metadata.
REQ-015 SHALL have port drop_valid  output  1  one-cycle pulse, entry discarded (no backpressure).
REQ-016 SHALL have port drop_rank  output  RANK_WIDTH  discarded entry rank.
REQ-017 SHALL have port drop_meta  output  META_WIDTH  discarded entry metadata.
REQ-018 SHALL have port num_entries  output  clog2(DEPTH+1)  occupancy.
REQ-019 SHALL have ports empty, full  output  1 each  num_entries==0, num_entries==DEPTH (registered).
REQ-020 SHALL have port drop_count  output  32  discarded-entry counter, saturating at 2^32-1.

Function
REQ-021 SHALL store entries in arrival order, slot 0 oldest; insert appends at slot num_entries; removal of any slot shifts younger slots down one.
REQ-022 SHALL select the head as minimum rank among valid slots; ties SHALL resolve to lowest slot index (FIFO among equal ranks).
REQ-023 SHALL select the overflow victim as maximum rank among valid slots; ties SHALL resolve to highest slot index (youngest).
REQ-024 deq_valid SHALL equal !empty; deq_rank/deq_meta SHALL be combinational from stored slots; an entry accepted at edge t SHALL be visible at deq from cycle t+1.
REQ-025 ins_ready SHALL be 1 in every cycle after reset deasserts (inserts are never backpressured; overflow handled by drop).
REQ-026 Insert while not full (or full with simultaneous dequeue): append, no drop.
REQ-027 Simultaneous dequeue and insert: remove head and append new entry in the same cycle; num_entries unchanged; new entry SHALL NOT be dequeued in that cycle.
REQ-028 Insert while full without dequeue, DROP_POLICY=0: if ins_rank < victim rank, remove victim, append new entry, drop port carries victim; else drop port carries incoming entry; num_entries stays DEPTH.
REQ-029 Insert while full without dequeue, DROP_POLICY=1: drop port carries incoming entry; storage unchanged.
REQ-030 drop_valid SHALL assert for exactly one cycle, registered, in the cycle after the drop decision; drop_count SHALL increment in that same edge.
REQ-031 Dequeue while empty SHALL be ignored (no state change).

Reset
REQ-032 On rst: num_entries=0, empty=1, full=0, deq_valid=0, ins_ready=0, drop_valid=0, drop_count=0, all slot valid bits cleared; slot rank/meta contents need not be reset.
REQ-033 rst asserted mid-operation SHALL discard all entries and any pending drop in that cycle; ins_ready SHALL return to 1 the cycle after rst deasserts.

Structure
REQ-034 A shared package/header pifo_pkg SHALL hold DROP_POLICY encodings (DROP_EVICT_MAX=0, DROP_TAIL=1) and the entry-width helper constant.
REQ-035 One sub-module pifo_minmax_tree SHALL implement the combinational min/max comparison tree with the tie rules of REQ-022/023, padding non-power-of-two DEPTH with invalid leaves.

Verification (DEPTH=4, DROP_POLICY=0 unless noted)
REQ-036 Insert ranks 5,3,7 -> dequeues return 3,5,7; empty=1 afterwards.
REQ-037 Insert (rank 4, meta 1),(4,2),(4,3) -> dequeue metas 1,2,3.
REQ-038 Fill 10,20,30,40; insert 25 -> drop_valid pulse with rank 40, drop_count=1, num_entries=4; dequeues 10,20,25,30.
REQ-039 Full with max 40; insert 50 -> drop rank 50, storage unchanged; DROP_POLICY=1 with insert 25 -> drop rank 25.
REQ-040 Full 10,20,30,40; same-cycle insert 1 and dequeue -> deq returns 10, no drop, next head 1, num_entries=4.
REQ-041 Three entries stored, rst for one cycle -> num_entries=0, empty=1, deq_valid=0, drop_count=0, ins_ready=1 next cycle.
